// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty instruction sequencer.
package bitty_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      EXEC,
      HALT,
      ERROR
   } seq_state_t;

   localparam logic [15:0] HALT_WORD = 16'hFFFF;
   localparam logic [15:0] COUNT_MAX = 16'hFFFF;

   function automatic logic is_halt(input logic [15:0] word);
      return word == HALT_WORD;
   endfunction

endpackage

// File: rtl/bitty_if.sv
// Instruction-memory read channel between the sequencer and its memory.
interface bitty_if #(
   parameter int ADDR_W = 8
) ();
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_valid;
   logic [15:0]       mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_valid, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_valid, output mem_rdata);
endinterface

// File: rtl/bitty_watchdog.sv
// EXEC-phase watchdog: counts enabled cycles since clear, flags the last allowed one.
module bitty_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // High in the cycle whose increment would reach TIMEOUT; the sequencer gates it with enable.
   assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/bitty_sequencer.sv
// Fetch/issue sequencer feeding 16-bit instruction words to bitty_core.
//   state | meaning
//   IDLE  | waiting for start after reset
//   FETCH | memory read outstanding at pc
//   ISSUE | one-cycle core_start with captured instruction
//   EXEC  | waiting for core_done under watchdog
//   HALT  | HALT_WORD fetched, run ended cleanly
//   ERROR | watchdog expired, run abandoned
module bitty_sequencer
   import bitty_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   bitty_if.master     mem,
   output logic [15:0] instruction,
   output logic        core_start,
   input  logic        core_done,
   output logic        busy,
   output logic        halted,
   output logic        error,
   output logic [15:0] instr_count
);

   seq_state_t        state, state_nxt;
   logic [ADDR_W-1:0] pc;
   logic              accept_start;
   logic              capture;
   logic              complete;
   logic              wd_clear;
   logic              wd_enable;
   logic              wd_expired;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      accept_start = 1'b0;
      capture      = 1'b0;
      complete     = 1'b0;
      wd_clear     = 1'b0;
      wd_enable    = 1'b0;
      mem.mem_req  = 1'b0;
      core_start   = 1'b0;
      busy         = 1'b0;
      halted       = 1'b0;
      error        = 1'b0;
      case (state)
         IDLE, HALT, ERROR: begin
            halted = (state == HALT);
            error  = (state == ERROR);
            if (start) begin
               accept_start = 1'b1;
               state_nxt    = FETCH;
            end
         end
         FETCH: begin
            mem.mem_req = 1'b1;
            busy        = 1'b1;
            if (mem.mem_valid) begin
               if (is_halt(mem.mem_rdata)) begin
                  state_nxt = HALT;
               end else begin
                  capture   = 1'b1;
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            core_start = 1'b1;
            busy       = 1'b1;
            wd_clear   = 1'b1;
            state_nxt  = EXEC;
         end
         EXEC: begin
            busy = 1'b1;
            // A completion arriving on the expiry cycle still counts.
            if (core_done) begin
               complete  = 1'b1;
               state_nxt = FETCH;
            end else begin
               wd_enable = 1'b1;
               if (wd_expired) begin
                  state_nxt = ERROR;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= '0;
         instr_count <= '0;
         instruction <= '0;
      end else begin
         if (accept_start) begin
            pc          <= '0;
            instr_count <= '0;
         end else if (complete) begin
            pc <= pc + 1'b1;
            if (instr_count != COUNT_MAX) begin
               instr_count <= instr_count + 16'd1;
            end
         end
         if (capture) begin
            instruction <= mem.mem_rdata;
         end
      end
   end

   assign mem.mem_addr = pc;

   bitty_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

endmodule

// File: doc/bitty_sequencer.md
BITTY_SEQUENCER -- requirements
Module: bitty_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum EXEC cycles allowed before the error state.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a pulse that begins a run at address 0.
REQ-006 SHALL have port mem_req, output, 1, instruction-memory read request.
REQ-007 SHALL have port mem_addr, output, ADDR_W, the read address (the PC).
REQ-008 SHALL have port mem_valid, input, 1, marks mem_rdata valid.
REQ-009 SHALL have port mem_rdata, input, 16, the fetched instruction word.
REQ-010 SHALL have port instruction, output, 16, registered instruction presented to bitty_core.
REQ-011 SHALL have port core_start, output, 1, one-cycle execute pulse to the core.
REQ-012 SHALL have port core_done, input, 1, the core's completion pulse.
REQ-013 SHALL have ports busy, halted and error, outputs, 1 each, reporting run status.
REQ-014 SHALL have port instr_count, output, 16, number of instructions completed in the current run.

Function
REQ-015 SHALL implement the states IDLE, FETCH, ISSUE, EXEC, HALT and ERROR.
REQ-016 IDLE/HALT/ERROR: on start SHALL go to FETCH next cycle, with pc=0, instr_count=0, halted=0, error=0 and busy=1.
REQ-017 FETCH: mem_req=1 and mem_addr=pc SHALL be held stable until mem_valid=1; wait length is unbounded.
REQ-018 FETCH with mem_valid and mem_rdata==HALT_WORD (16'hFFFF): SHALL go to HALT with halted=1, busy=0; instruction unchanged, pc unchanged.
REQ-019 FETCH with mem_valid and any other word: SHALL set instruction<=mem_rdata and go to ISSUE; core_start SHALL assert in the cycle after mem_valid.
REQ-020 ISSUE: core_start SHALL be 1 for exactly one cycle, then go to EXEC with the watchdog cleared to 0.
REQ-021 EXEC: on core_done, SHALL increment instr_count (saturating at 16'hFFFF), increment pc (wrapping 2^ADDR_W-1 -> 0), and re-enter FETCH, with mem_req=1 in the next cycle.
REQ-022 EXEC: the watchdog SHALL increment each cycle without core_done; on reaching TIMEOUT it SHALL go to ERROR with error=1, busy=0; core_done in that same cycle takes priority (counts as completion).
REQ-023 start while busy=1 SHALL be ignored; core_done outside EXEC and mem_valid outside FETCH SHALL be ignored.
REQ-024 halted and error SHALL be sticky until the next accepted start; mem_req SHALL be 0 in every state except FETCH.
REQ-025 instruction SHALL retain its last value in every state except on capture in FETCH.

Reset
REQ-026 While reset=0, SHALL asynchronously force the state to IDLE; pc, watchdog, instr_count and instruction to 0; and mem_req, core_start, busy, halted and error to 0.
REQ-027 Reset mid-run SHALL abandon the run without a core_start glitch; the first start after release SHALL begin at address 0.

Structure
REQ-028 The state enum typedef and HALT_WORD SHALL reside in the shared package bitty_pkg.
REQ-029 The watchdog SHALL be the sub-module bitty_watchdog (clear, enable, TIMEOUT parameter, expired output); everything else SHALL be in bitty_sequencer.

Verification
REQ-030 Memory holds 0x1234, 0x5678, 0xFFFF; mem_valid after 2 cycles; core_done 3 cycles after core_start -> two core_start pulses carrying 0x1234 then 0x5678, halted=1, instr_count=2, mem_addr sequence 0,1,2.
REQ-031 core_done never returns, TIMEOUT=4 -> error=1 and busy=0 exactly 4 cycles after entering EXEC; a later start clears error and refetches address 0.
REQ-032 ADDR_W=2, memory with no HALT_WORD -> mem_addr wraps 3->0, instr_count continues 4,5,...
REQ-033 start pulsed during FETCH and EXEC; spurious core_done in FETCH; mem_valid in EXEC -> no state change, no count change.
REQ-034 reset asserted during EXEC asynchronously -> all outputs 0 before the next clock edge; after release, start fetches address 0 with instr_count=0.
